// File: rtl/nbit_down_timer.sv
// Programmable down-counting timer with prescaled ticks, one-shot/periodic
// modes and pause/resume. Flags terminal count and expiry.
module nbit_down_timer #(
    parameter int unsigned N    = 32,
    parameter int unsigned STEP = 1,
    parameter int unsigned PW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [N-1:0]  pl,
    input  logic          start,
    input  logic          stop,
    input  logic          periodic,
    input  logic [PW-1:0] prescale,
    output logic [N-1:0]  count,
    output logic          tc,
    output logic          busy,
    output logic          expired
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [N-1:0] STEP_N = N'(STEP);

    state_t        state;
    logic [N-1:0]  reload;
    logic [PW-1:0] presc_cnt;

    // Priority per edge: rst > load > stop > start > tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            reload    <= '0;
            presc_cnt <= '0;
            tc        <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                count     <= pl;
                reload    <= pl;
                presc_cnt <= '0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!stop && start && (count != '0)) begin
                            state     <= RUN;
                            presc_cnt <= '0;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state <= PAUSE;
                        end else if (presc_cnt == prescale) begin
                            presc_cnt <= '0;
                            if (count > STEP_N) begin
                                count <= count - STEP_N;
                            end else begin
                                // Terminal tick: reload when periodic with a usable reload value
                                tc <= 1'b1;
                                if (periodic && (reload != '0)) begin
                                    count <= reload;
                                end else begin
                                    count <= '0;
                                    state <= DONE;
                                end
                            end
                        end else begin
                            presc_cnt <= presc_cnt + PW'(1);
                        end
                    end
                    PAUSE: begin
                        if (!stop && start) begin
                            state <= RUN;
                        end
                    end
                    DONE: begin
                        if (!stop && start && (reload != '0)) begin
                            count     <= reload;
                            presc_cnt <= '0;
                            state     <= RUN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy    = (state == RUN);
    assign expired = (state == DONE);

endmodule

// File: doc/nbit_down_timer.md
Name: nbit_down_timer

Overview:
Programmable N-bit down-counting timer, the counterpart to the team's N-bit up-counter. Software or an FSM preloads a terminal count; the block then decrements by a fixed step, on every cycle or on every prescaled tick, and flags expiry. It supports one-shot and periodic (auto-reload) modes plus pause/resume. It serves as the timeout and interval generator next to the existing up-counters.

Parameters:
N, 32, width of count, load value and reload register
STEP, 1, decrement applied per tick (1 <= STEP < 2^N)
PW, 8, width of prescale input and internal prescale counter

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, synchronous, active-high
load  input  1  copy pl into count and the reload register
pl  input  N  preload / reload value
start  input  1  begin or resume counting
stop  input  1  pause counting (count held)
periodic  input  1  1 = auto-reload at terminal count; 0 = one-shot
prescale  input  PW  tick every prescale+1 cycles while running
count  output  N  current count value
tc  output  1  terminal-count pulse, one cycle
busy  output  1  high in RUN
expired  output  1  high in DONE (one-shot finished)

Behaviour:
- States: IDLE, RUN, PAUSE, DONE.
- Reset values: count=0, reload=0, presc_cnt=0, tc=0, state=IDLE, busy=0, expired=0.
- Priority each edge: rst > load > stop > start > tick.
- load in any state:
  - count<=pl, reload<=pl, presc_cnt<=0, state<=IDLE, tc<=0.
  - Any start or stop in the same cycle is ignored.
- IDLE:
  - start with count!=0: RUN, presc_cnt<=0.
  - start with count==0: ignored, stays IDLE.
- RUN: presc_cnt increments each cycle. When presc_cnt==prescale, a tick occurs and presc_cnt<=0. prescale=0 gives a tick every cycle.
- On a tick:
  - If count>STEP: count<=count-STEP.
  - Else (terminal): tc<=1 for exactly one cycle.
    - One-shot: count<=0, state<=DONE.
    - Periodic: count<=reload, stay RUN. If reload==0, count<=0 and state<=DONE.
  - Count never wraps below 0.
- stop in RUN: state<=PAUSE; count and presc_cnt are held.
- PAUSE:
  - start: RUN, resuming presc_cnt where it stopped.
  - stop: no effect.
- DONE:
  - start with reload!=0: count<=reload, presc_cnt<=0, RUN.
  - start with reload==0: stays DONE.
  - stop: no effect.
- start and stop asserted together: stop wins.
- Latency:
  - start sampled at edge E0 puts the block in RUN after E0.
  - With prescale=0, the first decrement is at E1.
  - tc and expired are registered and become visible after the edge where the terminal tick occurs.
- busy = (state==RUN); expired = (state==DONE); both decoded from registered state.
- prescale must be held stable during RUN. If it changes mid-run, the tick fires when presc_cnt equals the new value. If presc_cnt already exceeds the new value, the tick fires after presc_cnt wraps at 2^PW.
- rst mid-operation returns all state to reset values at that edge, regardless of other inputs.

Test Plan:
- Reset then idle: assert rst 2 cycles with load=1, start=1 -> count=0, tc=0, busy=0, expired=0.
- One-shot, prescale=0: load pl=3, start at E0 -> count 3,2,1,0 after E0..E3; tc=1 only after E3; expired=1 from E3; busy=0 after E3.
- Periodic with prescale: pl=2, prescale=2, periodic=1, start -> count decrements every 3 cycles; the terminal tick reloads 2 with tc pulsed. Check 3 consecutive tc pulses spaced 6 cycles apart.
- Pause/resume and priority: RUN with count=10; stop for 5 cycles -> count held at its value and busy=0. Then start+stop together -> stays PAUSE. Then start -> decrements resume next tick. Then load pl=7 with start -> IDLE, count=7.
- STEP boundary: STEP=4, pl=6, one-shot -> count 6,2,0; tc on the 0 transition; no wrap.
- Zero and reset edge cases: start with count=0 -> stays IDLE. start in DONE restarts from reload. rst asserted mid-RUN with count=5 -> count=0, IDLE next cycle.
